// File: rtl/kgp_defs.sv
`default_nettype none
// ============================================================================
//  Module      : kgp_defs (package)
//  Description : State encodings, opcode values and opcode classes shared by
//                the multicycle sequencer and its datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package kgp_defs;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_IMM     = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_HALT    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } class_e;

    localparam logic [31:0] c_OP_RTYPE  = 32'h00;
    localparam logic [31:0] c_OP_IMM    = 32'h01;
    localparam logic [31:0] c_OP_LOAD   = 32'h02;
    localparam logic [31:0] c_OP_STORE  = 32'h03;
    localparam logic [31:0] c_OP_BRANCH = 32'h04;
    localparam logic [31:0] c_OP_HALT   = 32'h3F;

    // Opcode is zero-extended to 32 bits by the caller so any OPW up to 32 fits.
    function automatic class_e classify(input logic [31:0] op);
        class_e cls;
        case (op)
            c_OP_RTYPE:  cls = CLS_RTYPE;
            c_OP_IMM:    cls = CLS_IMM;
            c_OP_LOAD:   cls = CLS_LOAD;
            c_OP_STORE:  cls = CLS_STORE;
            c_OP_BRANCH: cls = CLS_BRANCH;
            c_OP_HALT:   cls = CLS_HALT;
            default:     cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage : kgp_defs
`default_nettype wire

// File: rtl/instr_counter.sv
`default_nettype none
// ============================================================================
//  Module      : instr_counter
//  Description : Free-running retired-instruction counter, wraps at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc_en_i) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule : instr_counter
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_sequencer
//  Description : Moore control FSM for a multicycle processor: fetch, decode,
//                execute, memory and write-back sequencing plus retire count.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer
    import kgp_defs::*;
#(
    parameter int OPW   = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [OPW-1:0]   opcode,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             alu_en,
    output logic             reg_write,
    output logic             mem2reg,
    output logic             illegal,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_e state_q, state_d;
    class_e class_q, class_d;
    logic   illegal_q, illegal_d;
    logic   retire_en;
    class_e opc_class;

    assign opc_class = classify(32'(opcode));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            class_q   <= CLS_RTYPE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        illegal_d = 1'b0;
        retire_en = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                class_d = opc_class;
                case (opc_class)
                    CLS_HALT: begin
                        state_d   = ST_HALT;
                        retire_en = 1'b1;
                    end
                    CLS_ILLEGAL: begin
                        state_d   = ST_FETCH;
                        illegal_d = 1'b1;
                    end
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_RTYPE, CLS_IMM:   state_d = ST_WB;
                    CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
                    CLS_BRANCH: begin
                        state_d   = ST_FETCH;
                        retire_en = 1'b1;
                    end
                    default:              state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (class_q == CLS_LOAD) begin
                        state_d = ST_WB;
                    end else begin
                        state_d   = ST_FETCH;
                        retire_en = 1'b1;
                    end
                end
            end
            ST_WB: begin
                state_d   = ST_FETCH;
                retire_en = 1'b1;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes decode only registered state so no input reaches an output.
    // FETCH enables stay high for the whole fetch; the datapath commits them
    // on the mem_ready cycle. The illegal flag is registered, so it shows up
    // in the cycle that follows DECODE.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        alu_en        = 1'b0;
        reg_write     = 1'b0;
        mem2reg       = 1'b0;
        halted        = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                mem_read = 1'b1;
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            ST_EXEC: begin
                alu_en        = 1'b1;
                pc_write_cond = (class_q == CLS_BRANCH);
            end
            ST_MEM: begin
                mem_read  = (class_q == CLS_LOAD);
                mem_write = (class_q == CLS_STORE);
            end
            ST_WB: begin
                reg_write = 1'b1;
                mem2reg   = (class_q == CLS_LOAD);
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal = illegal_q;
    assign state   = state_q;

    instr_counter #(
        .WIDTH (CNT_W)
    ) u_instr_counter (
        .clk      (clk),
        .rst      (rst),
        .inc_en_i (retire_en),
        .count_o  (retired)
    );

endmodule : multicycle_sequencer
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_sequencer
//  Description : Self-checking bench with an instruction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3,
                   S_MEM = 4, S_WB = 5, S_HALT = 6;
    localparam int K_RTYPE = 0, K_IMM = 1, K_LOAD = 2, K_STORE = 3,
                   K_BRANCH = 4, K_HALT = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;

    logic        mem_read, mem_write, ir_write, pc_write, pc_write_cond;
    logic        alu_en, reg_write, mem2reg, illegal, halted;
    logic [2:0]  state;
    logic [15:0] retired;

    logic        w_mem_read, w_mem_write, w_ir_write, w_pc_write, w_pc_write_cond;
    logic        w_alu_en, w_reg_write, w_mem2reg, w_illegal, w_halted;
    logic [2:0]  w_state;
    logic [3:0]  w_retired;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.OPW(6), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .alu_en(alu_en),
        .reg_write(reg_write), .mem2reg(mem2reg), .illegal(illegal),
        .halted(halted), .state(state), .retired(retired)
    );

    // Narrow-counter twin, so wrap-around is reachable in a short run.
    multicycle_sequencer #(.OPW(6), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .mem_read(w_mem_read), .mem_write(w_mem_write), .ir_write(w_ir_write),
        .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond), .alu_en(w_alu_en),
        .reg_write(w_reg_write), .mem2reg(w_mem2reg), .illegal(w_illegal),
        .halted(w_halted), .state(w_state), .retired(w_retired)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: instruction = list of phases ----------
    int          m_state = S_IDLE;
    int          m_cls   = K_RTYPE;
    int          m_path[$];
    bit          m_ill   = 1'b0;
    logic [15:0] m_ret   = 16'd0;
    logic [3:0]  m_retw  = 4'd0;

    function automatic int op_class(input int op);
        case (op)
            'h00: return K_RTYPE;
            'h01: return K_IMM;
            'h02: return K_LOAD;
            'h03: return K_STORE;
            'h04: return K_BRANCH;
            'h3F: return K_HALT;
            default: return -1;
        endcase
    endfunction

    task automatic model_step();
        bit done;
        bit ill;
        int c;
        done = 1'b0;
        ill  = 1'b0;
        if (m_state == S_IDLE) begin
            if (run) m_state = S_FETCH;
        end else if (m_state == S_FETCH) begin
            if (mem_ready) m_state = S_DECODE;
        end else if (m_state == S_DECODE) begin
            c = op_class(int'(opcode));
            if (c == K_HALT) begin
                m_state = S_HALT;
                done    = 1'b1;
            end else if (c < 0) begin
                m_state = S_FETCH;
                ill     = 1'b1;
            end else begin
                m_cls = c;
                m_path.delete();
                m_path.push_back(S_EXEC);
                if (c == K_LOAD || c == K_STORE) m_path.push_back(S_MEM);
                if (c == K_RTYPE || c == K_IMM || c == K_LOAD) m_path.push_back(S_WB);
                m_state = m_path.pop_front();
            end
        end else if (m_state != S_HALT) begin
            if (m_state == S_MEM && !mem_ready) begin
                m_state = S_MEM;
            end else if (m_path.size() == 0) begin
                m_state = S_FETCH;
                done    = 1'b1;
            end else begin
                m_state = m_path.pop_front();
            end
        end
        if (done) begin
            m_ret  = m_ret + 16'd1;
            m_retw = m_retw + 4'd1;
        end
        m_ill = ill;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = S_IDLE;
            m_cls   = K_RTYPE;
            m_path.delete();
            m_ill   = 1'b0;
            m_ret   = 16'd0;
            m_retw  = 4'd0;
        end else begin
            model_step();
        end
    end

    // ---------------- per-cycle compare --------------------------------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("state",         state,         m_state);
            chk("mem_read",      mem_read,      (m_state == S_FETCH) || (m_state == S_MEM && m_cls == K_LOAD));
            chk("mem_write",     mem_write,     m_state == S_MEM && m_cls == K_STORE);
            chk("ir_write",      ir_write,      m_state == S_FETCH);
            chk("pc_write",      pc_write,      m_state == S_FETCH);
            chk("pc_write_cond", pc_write_cond, m_state == S_EXEC && m_cls == K_BRANCH);
            chk("alu_en",        alu_en,        m_state == S_EXEC);
            chk("reg_write",     reg_write,     m_state == S_WB);
            chk("mem2reg",       mem2reg,       m_state == S_WB && m_cls == K_LOAD);
            chk("illegal",       illegal,       m_ill);
            chk("halted",        halted,        m_state == S_HALT);
            chk("retired",       retired,       m_ret);
            chk("rd_wr_excl",    mem_read & mem_write, 0);
            chk("w_state",       w_state,       m_state);
            chk("w_retired",     w_retired,     m_retw);
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic cyc(input bit r, input int op, input bit rdy);
        run       = r;
        opcode    = 6'(op);
        mem_ready = rdy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_state",     state, 0);
        chk("rst_mem_read",  mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_strobes",   {ir_write, pc_write, pc_write_cond, alu_en, reg_write, mem2reg}, 0);
        chk("rst_flags",     {illegal, halted}, 0);
        chk("rst_retired",   retired, 0);
        chk("rst_w_retired", w_retired, 0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
    endtask

    function automatic int rand_op();
        int r;
        r = $urandom_range(0, 99);
        if (r < 85) return $urandom_range(0, 4);
        if (r < 96) return $urandom_range(5, 62);
        return 'h3F;
    endfunction

    int e38[6] = '{1, 2, 3, 5, 1, 2};
    int e39[7] = '{1, 2, 3, 4, 4, 4, 5};
    int r39[7] = '{1, 1, 1, 0, 0, 1, 1};
    int e40[7] = '{1, 2, 3, 4, 1, 2, 3};
    int o40[7] = '{3, 3, 3, 3, 4, 4, 4};

    initial begin
        int cnt_a;
        int cnt_b;
        @(negedge clk);
        rst = 1'b0;
        chk("init_state", state, 0);
        chk("init_retired", retired, 0);
        cyc(1'b0, 0, 1'b1);
        chk("idle_hold", state, 0);

        // R-type at zero wait: 1,2,3,5,1
        cnt_a = 0;
        cyc(1'b1, 'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("r38_state", state, e38[i]);
            if (reg_write) cnt_a++;
            cyc(1'b0, 'h00, 1'b1);
        end
        chk("r38_end_state", state, 1);
        chk("r38_reg_write_cycles", cnt_a, 1);
        chk("r38_retired", retired, 1);

        // Load with two wait cycles in MEM
        cnt_a = 0;
        for (int i = 0; i < 7; i++) begin
            chk("r39_state", state, e39[i]);
            if (state == 3'd4 && mem_read) cnt_a++;
            if (i == 6) chk("r39_mem2reg", mem2reg, 1);
            cyc(1'b0, 'h02, r39[i][0]);
        end
        chk("r39_end_state", state, 1);
        chk("r39_mem_read_cycles", cnt_a, 3);
        chk("r39_retired", retired, 2);

        // Store then branch
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 7; i++) begin
            chk("r40_state", state, e40[i]);
            if (mem_write) cnt_a++;
            if (reg_write) cnt_b++;
            if (i == 6) chk("r40_pc_write_cond", pc_write_cond, 1);
            cyc(1'b1, o40[i], 1'b1);
        end
        chk("r40_mem_write_cycles", cnt_a, 1);
        chk("r40_reg_write_cycles", cnt_b, 0);
        chk("r40_retired", retired, 4);

        // Illegal opcode, then halt
        cyc(1'b1, 'h2A, 1'b1);
        chk("r41_decode", state, 2);
        cyc(1'b1, 'h2A, 1'b1);
        chk("r41_back_fetch", state, 1);
        chk("r41_illegal", illegal, 1);
        chk("r41_retired_same", retired, 4);
        cyc(1'b1, 'h3F, 1'b1);
        chk("r41_illegal_clear", illegal, 0);
        cyc(1'b1, 'h3F, 1'b1);
        for (int i = 0; i < 20; i++) begin
            chk("r41_halted", halted, 1);
            chk("r41_halt_state", state, 6);
            cyc($urandom_range(0, 1) == 1, rand_op(), $urandom_range(0, 1) == 1);
        end
        chk("r41_retired", retired, 5);

        // Reset in the middle of a stalled store
        do_reset();
        cyc(1'b1, 'h03, 1'b1);
        cyc(1'b0, 'h03, 1'b1);
        cyc(1'b0, 'h03, 1'b1);
        cyc(1'b0, 'h03, 1'b0);
        chk("r42_in_mem", state, 4);
        chk("r42_mem_write", mem_write, 1);
        do_reset();
        chk("r42_idle_wait", state, 0);
        cyc(1'b1, 'h00, 1'b1);
        chk("r42_restart", state, 1);

        // Counter wrap on the 4-bit twin
        do_reset();
        cyc(1'b1, 'h04, 1'b1);
        for (int i = 0; i < 45; i++) cyc(1'b1, 'h04, 1'b1);
        chk("r43_w_all_ones", w_retired, 'hF);
        chk("r43_retired15", retired, 15);
        for (int i = 0; i < 4; i++) cyc(1'b1, 'h00, 1'b1);
        chk("r43_w_wrap", w_retired, 0);
        chk("r43_retired16", retired, 16);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ((m_state == S_HALT && $urandom_range(0, 9) == 0) || $urandom_range(0, 299) == 0)
                do_reset();
            else
                cyc($urandom_range(0, 3) != 0, rand_op(), $urandom_range(0, 9) < 7);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
        $fatal(1, "watchdog");
    end

endmodule : tb_multicycle_sequencer
`default_nettype wire

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have parameter OPW, default 6, opcode width.
REQ-002 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port run, input, 1, a level that starts sequencing from IDLE.
REQ-006 SHALL have port opcode, input, OPW, the current instruction-register opcode, valid from DECODE onward.
REQ-007 SHALL have port mem_ready, input, 1, memory completion strobe for the access in progress.
REQ-008 SHALL have outputs mem_read, mem_write, ir_write, pc_write, pc_write_cond, alu_en and reg_write, each 1 bit wide, with the meanings given in the Function section.
REQ-009 SHALL have outputs mem2reg (1 bit, selects memory data for write-back), illegal (1 bit, unknown-opcode pulse), halted (1 bit), state (3 bits) and retired (CNT_W bits).

Function
REQ-010 SHALL implement a Moore FSM with these 3-bit state encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; the state output SHALL equal the current encoding.
REQ-011 SHALL transition from IDLE to FETCH when run=1, and SHALL otherwise remain in IDLE.
REQ-012 SHALL hold mem_read=1 throughout FETCH; when mem_ready=1 it SHALL assert ir_write=1 and pc_write=1 in that same cycle and then transition to DECODE.
REQ-013 SHALL, in DECODE, latch the opcode class into an internal register and transition in one cycle.
REQ-014 SHALL use these opcode classes: 0x00 R-type, 0x01 immediate, 0x02 load, 0x03 store, 0x04 branch, 0x3F halt.
REQ-015 SHALL, in DECODE, send the halt class to HALT and all known non-halt classes to EXEC.
REQ-016 SHALL, in DECODE, treat any other opcode as illegal: pulse illegal=1 for one cycle, return to FETCH, and not increment retired.
REQ-017 SHALL assert alu_en=1 for exactly one cycle in EXEC.
REQ-018 SHALL, in EXEC, assert pc_write_cond=1 for the branch class and then transition to FETCH.
REQ-019 SHALL, in EXEC, send the R-type and immediate classes to WB and the load and store classes to MEM.
REQ-020 SHALL, in MEM, hold mem_read=1 for a load or mem_write=1 for a store until mem_ready=1; it SHALL then go to WB after a load and to FETCH after a store.
REQ-021 SHALL, in WB, assert reg_write=1 for one cycle, with mem2reg=1 only for a load, and then transition to FETCH.
REQ-022 SHALL hold halted=1 in HALT with all strobes 0, and SHALL leave HALT only by reset.
REQ-023 SHALL increment retired by exactly 1 on each instruction completion: leaving WB, leaving MEM after a store, leaving EXEC after a branch, or entering HALT.
REQ-024 SHALL wrap retired from all-ones to zero without saturating or flagging.
REQ-025 SHALL achieve these latencies at zero wait (mem_ready=1 on the first cycle): branch 3 cycles, R-type/immediate/store 4 cycles, load 5 cycles.
REQ-026 SHALL extend latency by one cycle per cycle that mem_ready is low in FETCH or MEM.
REQ-027 SHALL ignore mem_ready outside FETCH and MEM.
REQ-028 SHALL ignore run outside IDLE; deasserting run mid-instruction SHALL have no effect.
REQ-029 SHALL never assert mem_read and mem_write in the same cycle.
REQ-030 SHALL drive all outputs as pure functions of state and the latched class, with no combinational path from any input to any output.

Reset
REQ-031 SHALL, on rst=1 and independent of clk, force state to IDLE, retired to 0 and the latched class to R-type.
REQ-032 SHALL, while rst=1, drive every strobe, illegal and halted to 0.
REQ-033 SHALL, when reset is asserted mid-FETCH or mid-MEM, drop mem_read/mem_write immediately and not complete the pending access.
REQ-034 SHALL, after rst deasserts, resume sequencing only after run=1 is sampled in IDLE.

Structure
REQ-035 SHALL take the state encodings, the opcode-class constants and the opcode values from a shared package/header, kgp_defs, which is also used by the datapath.
REQ-036 SHALL place retired in a natural sub-module, instr_counter (CNT_W-bit, with increment enable and async reset).
REQ-037 SHALL remain within 120-400 lines of RTL.

Verification
REQ-038 SHALL be verified by: reset, run=1, mem_ready=1, opcode=0x00 -> states 1,2,3,5,1; reg_write for one cycle in WB; retired=1.
REQ-039 SHALL be verified by: load with mem_ready low for 2 cycles in MEM -> mem_read held 3 cycles, then WB with mem2reg=1; total 7 cycles.
REQ-040 SHALL be verified by: store then branch -> mem_write for one cycle and no reg_write; pc_write_cond in EXEC; retired=2 after 7 cycles.
REQ-041 SHALL be verified by: opcode=0x2A -> illegal pulse in DECODE, back to FETCH, retired unchanged; then opcode=0x3F -> halted=1 held for 20 cycles, retired incremented by 1.
REQ-042 SHALL be verified by: rst asserted mid-MEM of a store -> mem_write=0 within the same cycle and state=IDLE; run=1 restarts at FETCH.
REQ-043 SHALL be verified by: preloading retired to 0xFFFF, then completing one R-type -> retired=0x0000.
